// File: rtl/add_sub_pipe.sv
// Pipelined add/subtract: the carry chain is cut into STAGES equal slices, one slice per stage,
// with a valid/ready handshake whose stages collapse bubbles independently.
module add_sub_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SUB,
    input  logic             CIN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             V,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);
    localparam int unsigned SW = WIDTH / STAGES;

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_ready;

    // A stage may load when it or any stage downstream of it is empty, or the sink accepts.
    always_comb begin
        w_ready = '0;
        for (int j = 0; j < STAGES; j++) begin
            w_ready[j] = OUT_READY | (|(~w_valid & ({STAGES{1'b1}} << j)));
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned LO   = k * SW;
        localparam int unsigned RW   = WIDTH - LO;
        localparam bit          LAST = (k == STAGES - 1);

        logic             w_in_valid;
        logic [RW-1:0]    w_a;
        logic [RW-1:0]    w_b;
        logic             w_cin;
        logic             w_sub;
        logic [SW:0]      w_sum;
        logic [LO+SW-1:0] w_res;
        logic             r_valid;
        logic             r_c;
        logic [LO+SW-1:0] r_res;

        // Subtraction is folded into the first stage: later slices only ever add.
        if (k == 0) begin : g_src
            assign w_in_valid = IN_VALID;
            assign w_a        = I0;
            assign w_b        = SUB ? ~I1 : I1;
            assign w_cin      = CIN ^ SUB;
            assign w_sub      = SUB;
            assign w_res      = w_sum[SW-1:0];
        end else begin : g_src
            assign w_in_valid = g_st[k-1].r_valid;
            assign w_a        = g_st[k-1].g_fwd.r_a;
            assign w_b        = g_st[k-1].g_fwd.r_b;
            assign w_cin      = g_st[k-1].r_c;
            assign w_sub      = g_st[k-1].g_fwd.r_sub;
            assign w_res      = {w_sum[SW-1:0], g_st[k-1].r_res};
        end

        assign w_sum      = {1'b0, w_a[SW-1:0]} + {1'b0, w_b[SW-1:0]} + {{SW{1'b0}}, w_cin};
        assign w_valid[k] = r_valid;

        // The last stage stores the borrow (inverted carry) when subtracting.
        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                r_valid <= 1'b0;
                r_c     <= 1'b0;
                r_res   <= '0;
            end else if (w_ready[k]) begin
                r_valid <= w_in_valid;
                r_res   <= w_res;
                r_c     <= LAST ? (w_sum[SW] ^ w_sub) : w_sum[SW];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-SW-1:0] r_a;
            logic [RW-SW-1:0] r_b;
            logic             r_sub;

            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sub <= 1'b0;
                end else if (w_ready[k]) begin
                    r_a   <= w_a[RW-1:SW];
                    r_b   <= w_b[RW-1:SW];
                    r_sub <= w_sub;
                end
            end
        end else begin : g_last
            logic r_v;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    r_v <= 1'b0;
                end else if (w_ready[k]) begin
                    r_v <= w_a[SW-1] ^ w_b[SW-1] ^ w_sum[SW-1] ^ w_sum[SW];
                end
            end
        end
    end

    assign IN_READY  = w_ready[0];
    assign OUT_VALID = w_valid[STAGES-1];
    assign O         = g_st[STAGES-1].r_res;
    assign COUT      = g_st[STAGES-1].r_c;
    assign V         = g_st[STAGES-1].g_last.r_v;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed handshake/reset scenarios on an 8/2 instance, then
// randomized streams on several WIDTH/STAGES instances, all scored against an arithmetic model.
module tb_add_sub_pipe;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       c;
        logic [7:0] o;
        logic       co;
        logic       vv;
    } vec_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rstn_sw;
    logic [W-1:0] i0, i1, o;
    logic         sub, cin, in_valid, in_ready, cout, v, out_valid, out_ready;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    int          sweep_done = 0;
    bit          sweep_go = 1'b0;
    bit          acc_last = 1'b0;
    logic [63:0] exp_q[$];
    vec_t        vecs[5];

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
        .CLK(clk), .RESETN(rstn), .I0(i0), .I1(i1), .SUB(sub), .CIN(cin),
        .IN_VALID(in_valid), .IN_READY(in_ready), .O(o), .COUT(cout), .V(v),
        .OUT_VALID(out_valid), .OUT_READY(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: returns {V, COUT, O} packed at bits w+1, w, w-1:0, from plain integer arithmetic.
    function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic c);
        logic [63:0] full;
        longint      sa, sb, sr, lim;
        logic        cout_e, v_e;
        lim = longint'(64'd1 << (w - 1));
        sa  = longint'(a << (64 - w)) >>> (64 - w);
        sb  = longint'(b << (64 - w)) >>> (64 - w);
        if (!s) begin
            full   = a + b + 64'(c);
            cout_e = full[w];
            sr     = sa + sb + longint'(c);
        end else begin
            full   = a - b - 64'(c);
            cout_e = (a < b + 64'(c));
            sr     = sa - sb - longint'(c);
        end
        v_e = (sr >= lim) || (sr < -lim);
        return (64'(v_e) << (w + 1)) | (64'(cout_e) << w) | (full & ((64'd1 << w) - 64'd1));
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return m;
            default: return {$urandom(), $urandom()} & m;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_op();
        i0  = W'(pick(W));
        i1  = W'(pick(W));
        sub = 1'($urandom());
        cin = 1'($urandom());
    endtask

    // Scoreboard for the main instance: acceptances push, output handshakes pop.
    always @(negedge clk) begin
        acc_last = 1'b0;
        if (rstn) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(W, 64'(i0), 64'(i1), sub, cin));
                n_acc++;
                acc_last = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("scb_extra", 64'(exp_q.size()), 64'd1);
                else check("scb", 64'({v, cout, o}), exp_q.pop_front());
                n_out++;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int unsigned GW = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 16 : 32;
        localparam int unsigned GS = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 4 : 2;

        logic [GW-1:0] a, b, r;
        logic          s, c, iv, ir, co, vv, ov, ordy;
        logic [63:0]   q[$];
        bit            acc = 1'b0;

        add_sub_pipe #(.WIDTH(GW), .STAGES(GS)) u_dut (
            .CLK(clk), .RESETN(rstn_sw), .I0(a), .I1(b), .SUB(s), .CIN(c),
            .IN_VALID(iv), .IN_READY(ir), .O(r), .COUT(co), .V(vv),
            .OUT_VALID(ov), .OUT_READY(ordy)
        );

        always @(negedge clk) begin
            acc = 1'b0;
            if (rstn_sw) begin
                if (iv && ir) begin
                    q.push_back(model(GW, 64'(a), 64'(b), s, c));
                    acc = 1'b1;
                end
                if (ov && ordy) begin
                    if (q.size() == 0) check($sformatf("sweep%0d_extra", g), 64'(q.size()), 64'd1);
                    else check($sformatf("sweep%0d_w%0d_s%0d", g, GW, GS), 64'({vv, co, r}), q.pop_front());
                end
            end
        end

        initial begin
            iv = 1'b0; a = '0; b = '0; s = 1'b0; c = 1'b0; ordy = 1'b1;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int n = 0; n < 300; n++) begin
                if (!iv || acc) begin
                    iv = ($urandom_range(0, 3) != 0);
                    a  = GW'(pick(GW));
                    b  = GW'(pick(GW));
                    s  = 1'($urandom());
                    c  = 1'($urandom());
                end
                ordy = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
            iv   = 1'b0;
            ordy = 1'b1;
            for (int n = 0; n < 40 && q.size() != 0; n++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("sweep%0d_drain", g), 64'(q.size()), 64'd0);
            sweep_done++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  ov_seen;
        logic [63:0] snap;
        int          n0, o0;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

        rstn = 1'b0; rstn_sw = 1'b0;
        in_valid = 1'b0; i0 = '0; i1 = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        snap = '0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'({v, cout, o}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1; rstn_sw = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time, with latency checks.
        for (int i = 0; i < 5; i++) begin
            i0 = vecs[i].a; i1 = vecs[i].b; sub = vecs[i].s; cin = vecs[i].c; in_valid = 1'b1;
            check("vec_in_ready", 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            check("vec_lat_early", 64'(out_valid), 64'd0);
            tick();
            check("vec_lat_valid", 64'(out_valid), 64'd1);
            check($sformatf("vec%0d", i), 64'({v, cout, o}), 64'({vecs[i].vv, vecs[i].co, vecs[i].o}));
            tick();
        end

        // Back-to-back alternating add/sub.
        o0 = n_out;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                new_op();
                sub = 1'(k);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            ov_seen[k] = out_valid;
        end
        check("b2b_pattern", 64'(ov_seen), 64'(7'b0011110));
        check("b2b_count", 64'(n_out - o0), 64'd4);

        // Backpressure: sink stalls for 5 cycles with a source that always offers.
        out_ready = 1'b0;
        n0 = n_acc; o0 = n_out;
        new_op();
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) begin
                snap = 64'({out_valid, v, cout, o});
                check("bp_out_valid", 64'(out_valid), 64'd1);
            end else if (k > 1) begin
                check("bp_hold", 64'({out_valid, v, cout, o}), snap);
            end
            if (acc_last) new_op();
        end
        check("bp_accepted", 64'(n_acc - n0), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && !(exp_q.size() == 0 && !in_valid); k++) begin
            tick();
            if (acc_last) in_valid = 1'b0;
        end
        check("bp_delivered", 64'(n_out - o0), 64'd3);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        n0 = n_acc;
        new_op();
        in_valid = 1'b1;
        tick();
        new_op();
        tick();
        in_valid = 1'b0;
        check("rm_accepted", 64'(n_acc - n0), 64'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("rm_out_valid", 64'(out_valid), 64'd0);
        check("rm_result", 64'({v, cout, o}), 64'd0);
        check("rm_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        tick();
        tick();
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        o0 = n_out;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rm_no_stale", 64'(out_valid), 64'd0);
        end
        n0 = n_acc;
        i0 = vecs[0].a; i1 = vecs[0].b; sub = vecs[0].s; cin = vecs[0].c; in_valid = 1'b1;
        check("rm_ready_first", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("rm_first_acc", 64'(n_acc - n0), 64'd1);
        tick();
        check("rm_result_valid", 64'(out_valid), 64'd1);
        tick();
        check("rm_delivered", 64'(n_out - o0), 64'd1);

        // Random traffic with random sink stalls.
        in_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                new_op();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        check("rand_drain", 64'(exp_q.size()), 64'd0);

        sweep_go = 1'b1;
        for (int k = 0; k < 2000 && sweep_done < 4; k++) tick();
        check("sweep_done", 64'(sweep_done), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..64).
REQ-002 The block SHALL have parameter STAGES, default 2, number of carry-chain pipeline stages (legal 1..WIDTH, WIDTH divisible by STAGES).
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port RESETN  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port I0  input  WIDTH  minuend/first addend.
REQ-006 The block SHALL have port I1  input  WIDTH  subtrahend/second addend.
REQ-007 The block SHALL have port SUB  input  1  mode per transaction: 0 = add, 1 = subtract.
REQ-008 The block SHALL have port CIN  input  1  carry-in (add) or borrow-in (subtract).
REQ-009 The block SHALL have port IN_VALID  input  1  operands valid this cycle.
REQ-010 The block SHALL have port IN_READY  output  1  block accepts operands this cycle.
REQ-011 The block SHALL have port O  output  WIDTH  result.
REQ-012 The block SHALL have port COUT  output  1  carry-out (add) or borrow-out (subtract).
REQ-013 The block SHALL have port V  output  1  two's-complement signed overflow.
REQ-014 The block SHALL have port OUT_VALID  output  1  O/COUT/V hold a valid result.
REQ-015 The block SHALL have port OUT_READY  input  1  downstream accepts result.

Function
REQ-016 Add mode SHALL compute {COUT,O} = I0 + I1 + CIN, unsigned, WIDTH+1 bits.
REQ-017 Subtract mode SHALL compute O = (I0 - I1 - CIN) mod 2^WIDTH via I0 + ~I1 + ~CIN; COUT = 1 iff I0 < I1 + CIN unsigned (borrow, i.e. inverted raw carry).
REQ-018 V SHALL equal carry into MSB XOR raw carry out of MSB, in both modes.
REQ-019 Carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k SHALL be evaluated in pipeline stage k, with the slice's carry registered between stages.
REQ-020 Operand bits of not-yet-evaluated slices, and SUB, SHALL be carried forward in per-stage registers; completed result bits SHALL be carried forward likewise.
REQ-021 Latency SHALL be exactly STAGES cycles from accepted input (IN_VALID & IN_READY at edge n) to OUT_VALID high after edge n+STAGES-1, absent stalls.
REQ-022 Throughput SHALL be one transaction per cycle when OUT_READY is held high.
REQ-023 Each stage SHALL have a valid bit; stage advances when downstream stage is empty or advancing (per-stage bubble collapse).
REQ-024 IN_READY SHALL be high iff stage 0 is empty or stage 0 advances this cycle; IN_READY SHALL be combinational from stage state and OUT_READY only, never from IN_VALID.
REQ-025 While OUT_VALID=1 and OUT_READY=0, O, COUT, V, OUT_VALID SHALL hold stable.
REQ-026 Input with IN_VALID=1 and IN_READY=0 SHALL not be captured; upstream holds it.
REQ-027 Transactions SHALL exit in acceptance order; none dropped or duplicated; add and sub transactions SHALL interleave freely without flush.
REQ-028 STAGES=1 SHALL degenerate to a single registered full-width add/sub with the same handshake.
REQ-029 Data registers MAY update while their stage valid bit is 0; outputs are only meaningful while OUT_VALID=1.

Reset
REQ-030 RESETN low SHALL asynchronously clear all stage valid bits; OUT_VALID=0, O=0, COUT=0, V=0 immediately.
REQ-031 IN_READY SHALL be 1 during and after reset (pipeline empty).
REQ-032 Reset asserted mid-operation SHALL discard all in-flight transactions; first acceptance after RESETN rises SHALL be on the first rising edge with IN_VALID=1.
REQ-033 Reset deassertion SHALL be used as-is; no internal synchroniser.

Verification (WIDTH=8, STAGES=2 unless noted)
REQ-034 Add: I0=0xFF, I1=0x01, CIN=0, SUB=0 -> two cycles later O=0x00, COUT=1, V=0; I0=0x7F, I1=0x01 -> O=0x80, COUT=0, V=1.
REQ-035 Subtract: I0=0x05, I1=0x07, CIN=0, SUB=1 -> O=0xFE, COUT=1, V=0; I0=0x80, I1=0x01 -> O=0x7F, COUT=0, V=1; I0=0x10, I1=0x0F, CIN=1 -> O=0x00, COUT=0.
REQ-036 Back-to-back: 4 alternating add/sub transactions, OUT_READY=1 -> 4 results on 4 consecutive cycles, correct order and values.
REQ-037 Backpressure: hold OUT_READY=0 for 5 cycles with IN_VALID=1 -> exactly 2 transactions accepted, IN_READY low afterwards, output stable; release -> all results delivered in order, no loss.
REQ-038 Reset mid-flight: assert RESETN=0 with 2 in-flight -> OUT_VALID=0 immediately, no stale result after release.
REQ-039 Parameter sweep: random operands for (WIDTH,STAGES) in {(8,1),(8,8),(16,4),(32,2)} checked against reference model, including all-zero and all-ones operands.
